// File: rtl/rega_pkg.sv
// Shared types for the multi-zone irrigation controller: FSM states, irrigation
// mode and tank level codes, plus the level-decoding helpers.
package rega_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      REGA  = 2'b01,
      PAUSA = 2'b10
   } estado_t;

   typedef enum logic {
      ASPERSAO    = 1'b0,
      GOTEJAMENTO = 1'b1
   } modo_t;

   typedef logic [1:0] nivel_t;

   localparam nivel_t NIVEL_CRITICO = 2'b00;
   localparam nivel_t NIVEL_BAIXO   = 2'b01;
   localparam nivel_t NIVEL_MEDIO   = 2'b10;
   localparam nivel_t NIVEL_ALTO    = 2'b11;

   function automatic nivel_t nivel_de(input logic h, input logic m, input logic l);
      nivel_t n;
      if (h) begin
         n = NIVEL_ALTO;
      end else if (m) begin
         n = NIVEL_MEDIO;
      end else if (l) begin
         n = NIVEL_BAIXO;
      end else begin
         n = NIVEL_CRITICO;
      end
      return n;
   endfunction

   // A wet probe above a dry one can only mean a faulty probe
   function automatic logic erro_de(input logic h, input logic m, input logic l);
      return (h & ~m) | (m & ~l);
   endfunction

endpackage

// File: rtl/rega_multizona_if.sv
// Sensor inputs and actuator/status outputs of the irrigation controller.
interface rega_multizona_if
   import rega_pkg::*;
#(
   parameter int N_ZONAS = 4
);
   localparam int ZW = $clog2(N_ZONAS);

   logic               H;
   logic               M;
   logic               L;
   logic [N_ZONAS-1:0] Us;
   logic               Ua;
   logic               T;
   logic [N_ZONAS-1:0] Bs;
   logic [N_ZONAS-1:0] Vs;
   logic               Ve;
   logic               Al;
   logic               Erro;
   nivel_t             Nivel;
   logic [ZW-1:0]      Zona;
   logic               Ocupado;
   logic [N_ZONAS-1:0] Falha;

   modport master (
      output H, M, L, Us, Ua, T,
      input  Bs, Vs, Ve, Al, Erro, Nivel, Zona, Ocupado, Falha
   );

   modport slave (
      input  H, M, L, Us, Ua, T,
      output Bs, Vs, Ve, Al, Erro, Nivel, Zona, Ocupado, Falha
   );
endinterface

// File: rtl/filtro_sensor.sv
// Two-flop synchroniser followed by a debounce filter: the output follows the
// input only after it has held a new value for DEB_CYC consecutive cycles.
module filtro_sensor #(
   parameter int DEB_CYC = 1000
) (
   input  logic clock,
   input  logic Rst,
   input  logic din,
   output logic dout
);
   localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

   logic          sinc1_r;
   logic          sinc2_r;
   logic          filt_r;
   logic [CW-1:0] estab_r;

   // Synchroniser chain and stability counter
   always_ff @(posedge clock) begin
      if (!Rst) begin
         sinc1_r <= 1'b0;
         sinc2_r <= 1'b0;
         filt_r  <= 1'b0;
         estab_r <= '0;
      end else begin
         sinc1_r <= din;
         sinc2_r <= sinc1_r;
         if (sinc2_r == filt_r) begin
            estab_r <= '0;
         end else if (estab_r == CW'(DEB_CYC - 1)) begin
            filt_r  <= sinc2_r;
            estab_r <= '0;
         end else begin
            estab_r <= estab_r + CW'(1);
         end
      end
   end

   assign dout = filt_r;
endmodule

// File: rtl/rega_multizona.sv
// Multi-zone irrigation controller: filtered tank/soil/climate sensors drive a
// tank inlet hysteresis and a round-robin IDLE/REGA/PAUSA zone scheduler.
module rega_multizona
   import rega_pkg::*;
#(
   parameter int N_ZONAS   = 4,
   parameter int DEB_CYC   = 1000,
   parameter int MIN_ON    = 5000,
   parameter int MAX_ON    = 50000,
   parameter int PAUSA_CYC = 16
) (
   input  logic             clock,
   input  logic             Rst,
   rega_multizona_if.slave  bus
);
   localparam int ZW = $clog2(N_ZONAS);
   localparam int CW = $clog2(MAX_ON + 1);
   localparam int PW = (PAUSA_CYC > 1) ? $clog2(PAUSA_CYC) : 1;
   localparam int NS = N_ZONAS + 5;

   logic [NS-1:0]      sensor_s;
   logic [NS-1:0]      filt_s;
   logic               h_s, m_s, l_s, ua_s, t_s, erro_s;
   logic [N_ZONAS-1:0] us_s;
   nivel_t             nivel_s;

   estado_t            estado_r, estado_nx_s;
   modo_t              modo_r, modo_nx_s;
   logic [ZW-1:0]      ptr_r, ptr_nx_s, zona_r, zona_nx_s, cand_s, idx_s, prox_s;
   logic               achou_s;
   logic [CW-1:0]      cnt_r, cnt_nx_s;
   logic [PW-1:0]      pausa_r, pausa_nx_s;
   logic [N_ZONAS-1:0] falha_r, falha_nx_s, bs_r, bs_nx_s, vs_r, vs_nx_s;
   logic               ocupado_r, ve_r, al_r, erro_r;
   nivel_t             nivel_r;

   assign sensor_s = {bus.T, bus.Ua, bus.Us, bus.L, bus.M, bus.H};

   for (genvar g = 0; g < NS; g++) begin : g_filtro
      filtro_sensor #(.DEB_CYC(DEB_CYC)) u_filtro (
         .clock (clock),
         .Rst   (Rst),
         .din   (sensor_s[g]),
         .dout  (filt_s[g])
      );
   end

   assign h_s     = filt_s[0];
   assign m_s     = filt_s[1];
   assign l_s     = filt_s[2];
   assign us_s    = filt_s[3 +: N_ZONAS];
   assign ua_s    = filt_s[N_ZONAS + 3];
   assign t_s     = filt_s[N_ZONAS + 4];
   assign erro_s  = erro_de(h_s, m_s, l_s);
   assign nivel_s = nivel_de(h_s, m_s, l_s);
   assign prox_s  = (zona_r == ZW'(N_ZONAS - 1)) ? '0 : zona_r + ZW'(1);

   // Level outputs and inlet valve: open at low/critical, close at high or on probe fault
   always_ff @(posedge clock) begin
      if (!Rst) begin
         ve_r    <= 1'b0;
         al_r    <= 1'b1;
         erro_r  <= 1'b0;
         nivel_r <= NIVEL_CRITICO;
      end else begin
         erro_r  <= erro_s;
         nivel_r <= nivel_s;
         al_r    <= erro_s | (nivel_s == NIVEL_CRITICO);
         if (h_s || erro_s) begin
            ve_r <= 1'b0;
         end else if (nivel_s <= NIVEL_BAIXO) begin
            ve_r <= 1'b1;
         end else begin
            ve_r <= ve_r;
         end
      end
   end

   // Round-robin search from ptr for the first dry zone without a timeout flag
   always_comb begin
      achou_s = 1'b0;
      cand_s  = '0;
      idx_s   = '0;
      for (int i = 0; i < N_ZONAS; i++) begin
         idx_s = ZW'((int'(ptr_r) + i) % N_ZONAS);
         if (!achou_s && us_s[idx_s] && !falha_r[idx_s]) begin
            achou_s = 1'b1;
            cand_s  = idx_s;
         end else begin
            achou_s = achou_s;
         end
      end
   end

   // Next-state logic; abort outranks timeout so an aborted run never flags Falha
   always_comb begin
      estado_nx_s = estado_r;
      modo_nx_s   = modo_r;
      ptr_nx_s    = ptr_r;
      zona_nx_s   = zona_r;
      cnt_nx_s    = cnt_r;
      pausa_nx_s  = pausa_r;
      falha_nx_s  = falha_r;
      case (estado_r)
         IDLE: begin
            if (achou_s && l_s && !erro_s) begin
               estado_nx_s = REGA;
               zona_nx_s   = cand_s;
               cnt_nx_s    = '0;
               modo_nx_s   = (!t_s && !ua_s && m_s) ? ASPERSAO : GOTEJAMENTO;
            end else begin
               estado_nx_s = IDLE;
            end
         end
         REGA: begin
            if (erro_s || !l_s || (modo_r == ASPERSAO && !m_s)) begin
               estado_nx_s = PAUSA;
               ptr_nx_s    = prox_s;
               pausa_nx_s  = '0;
            end else if (cnt_r >= CW'(MIN_ON) && !us_s[zona_r]) begin
               estado_nx_s = PAUSA;
               ptr_nx_s    = prox_s;
               pausa_nx_s  = '0;
            end else if (cnt_r == CW'(MAX_ON - 1)) begin
               estado_nx_s         = PAUSA;
               ptr_nx_s            = prox_s;
               pausa_nx_s          = '0;
               falha_nx_s[zona_r]  = 1'b1;
            end else if (cnt_r != CW'(MAX_ON)) begin
               cnt_nx_s = cnt_r + CW'(1);
            end else begin
               cnt_nx_s = cnt_r;
            end
         end
         PAUSA: begin
            if (pausa_r == PW'(PAUSA_CYC - 1)) begin
               estado_nx_s = IDLE;
            end else begin
               pausa_nx_s = pausa_r + PW'(1);
            end
         end
         default: begin
            estado_nx_s = IDLE;
         end
      endcase

      bs_nx_s = '0;
      vs_nx_s = '0;
      if (estado_nx_s == REGA) begin
         if (modo_nx_s == ASPERSAO) begin
            bs_nx_s[zona_nx_s] = 1'b1;
         end else begin
            vs_nx_s[zona_nx_s] = 1'b1;
         end
      end else begin
         bs_nx_s = '0;
         vs_nx_s = '0;
      end
   end

   // Scheduler state and valve outputs, aligned with the state they belong to
   always_ff @(posedge clock) begin
      if (!Rst) begin
         estado_r  <= IDLE;
         modo_r    <= ASPERSAO;
         ptr_r     <= '0;
         zona_r    <= '0;
         cnt_r     <= '0;
         pausa_r   <= '0;
         falha_r   <= '0;
         bs_r      <= '0;
         vs_r      <= '0;
         ocupado_r <= 1'b0;
      end else begin
         estado_r  <= estado_nx_s;
         modo_r    <= modo_nx_s;
         ptr_r     <= ptr_nx_s;
         zona_r    <= zona_nx_s;
         cnt_r     <= cnt_nx_s;
         pausa_r   <= pausa_nx_s;
         falha_r   <= falha_nx_s;
         bs_r      <= bs_nx_s;
         vs_r      <= vs_nx_s;
         ocupado_r <= (estado_nx_s == REGA);
      end
   end

   assign bus.Bs      = bs_r;
   assign bus.Vs      = vs_r;
   assign bus.Ve      = ve_r;
   assign bus.Al      = al_r;
   assign bus.Erro    = erro_r;
   assign bus.Nivel   = nivel_r;
   assign bus.Zona    = zona_r;
   assign bus.Ocupado = ocupado_r;
   assign bus.Falha   = falha_r;
endmodule

// File: tb/tb_rega_multizona.sv
// Scoreboard bench: each expected irrigation episode is queued by the stimulus
// and checked by an independent monitor when Ocupado rises and falls.
module tb_rega_multizona;
   localparam int NZ = 4;

   typedef struct {
      int         zona;
      logic [3:0] bs;
      logic [3:0] vs;
      int         dur;
      int         gap;
      logic [3:0] falha;
   } ep_t;

   logic clock = 1'b0;
   logic Rst;
   int   checks = 0;
   int   errors = 0;
   ep_t  fila[$];

   rega_multizona_if #(.N_ZONAS(NZ)) bus ();

   rega_multizona #(
      .N_ZONAS(NZ), .DEB_CYC(4), .MIN_ON(8), .MAX_ON(32), .PAUSA_CYC(4)
   ) dut (
      .clock (clock),
      .Rst   (Rst),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nome, got, exp);
      end
   endtask

   task automatic push(input int z, input logic gota, input int dur, input int gap,
                       input logic [3:0] falha);
      ep_t e;
      e.zona  = z;
      e.bs    = gota ? 4'b0000 : 4'(1 << z);
      e.vs    = gota ? 4'(1 << z) : 4'b0000;
      e.dur   = dur;
      e.gap   = gap;
      e.falha = falha;
      fila.push_back(e);
   endtask

   task automatic ciclos(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic espera_ocup(input logic v, input string nome);
      int n;
      n = 0;
      @(negedge clock);
      while (bus.Ocupado !== v && n < 200) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (bus.Ocupado !== v) begin
         errors++;
         $display("FAIL %s: Ocupado=%b after 200 cycles, expected %b", nome, bus.Ocupado, v);
      end
   endtask

   task automatic verifica_reset(input string nome);
      chk({nome, "_bs"},      32'(bus.Bs),      32'd0);
      chk({nome, "_vs"},      32'(bus.Vs),      32'd0);
      chk({nome, "_ve"},      32'(bus.Ve),      32'd0);
      chk({nome, "_al"},      32'(bus.Al),      32'd1);
      chk({nome, "_erro"},    32'(bus.Erro),    32'd0);
      chk({nome, "_nivel"},   32'(bus.Nivel),   32'd0);
      chk({nome, "_zona"},    32'(bus.Zona),    32'd0);
      chk({nome, "_ocupado"}, 32'(bus.Ocupado), 32'd0);
      chk({nome, "_falha"},   32'(bus.Falha),   32'd0);
   endtask

   // Monitor: pops one expected episode per REGA run and tracks its length and the preceding gap
   initial begin : monitor
      ep_t  e;
      logic ativo;
      logic tem;
      int   dur;
      int   gap;
      ativo = 1'b0;
      tem   = 1'b0;
      dur   = 0;
      gap   = 0;
      forever begin
         @(posedge clock);
         #1;
         if (bus.Ocupado === 1'b1) begin
            if (!ativo) begin
               ativo = 1'b1;
               dur   = 0;
               if (fila.size() == 0) begin
                  tem = 1'b0;
                  checks++;
                  errors++;
                  $display("FAIL episodio_inesperado: zone %0d irrigating, none expected", bus.Zona);
               end else begin
                  e   = fila.pop_front();
                  tem = 1'b1;
                  if (e.gap >= 0) chk("pausa_gap", 32'(gap), 32'(e.gap));
               end
            end
            dur++;
            if (tem) begin
               chk("zona", 32'(bus.Zona), 32'(e.zona));
               chk("bs",   32'(bus.Bs),   32'(e.bs));
               chk("vs",   32'(bus.Vs),   32'(e.vs));
            end
         end else begin
            if (ativo) begin
               ativo = 1'b0;
               gap   = 0;
               if (tem) begin
                  chk("duracao", 32'(dur),       32'(e.dur));
                  chk("falha",   32'(bus.Falha), 32'(e.falha));
               end
            end
            gap++;
            chk("saidas_ociosas", 32'(bus.Bs | bus.Vs), 32'd0);
         end
      end
   end

   initial begin : estimulo
      Rst = 1'b0;
      bus.H = 1'b0; bus.M = 1'b0; bus.L = 1'b0;
      bus.Ua = 1'b0; bus.T = 1'b0; bus.Us = 4'b0000;
      ciclos(3);
      verifica_reset("reset");
      Rst = 1'b1;
      ciclos(3);
      chk("ve_vazio", 32'(bus.Ve), 32'd1);
      chk("al_vazio", 32'(bus.Al), 32'd1);

      // Tank level sequence and inlet hysteresis
      bus.H = 1'b1; bus.M = 1'b1; bus.L = 1'b1;
      ciclos(8);
      chk("nivel_11", 32'(bus.Nivel), 32'd3);
      chk("ve_11",    32'(bus.Ve),    32'd0);
      chk("al_11",    32'(bus.Al),    32'd0);
      chk("erro_11",  32'(bus.Erro),  32'd0);
      bus.H = 1'b0; bus.M = 1'b0;
      ciclos(8);
      chk("nivel_01", 32'(bus.Nivel), 32'd1);
      chk("ve_01",    32'(bus.Ve),    32'd1);
      chk("al_01",    32'(bus.Al),    32'd0);
      bus.M = 1'b1;
      ciclos(8);
      chk("nivel_10", 32'(bus.Nivel), 32'd2);
      chk("ve_10",    32'(bus.Ve),    32'd1);
      bus.H = 1'b1;
      ciclos(8);
      chk("nivel_11b", 32'(bus.Nivel), 32'd3);
      chk("ve_11b",    32'(bus.Ve),    32'd0);
      bus.H = 1'b0;
      ciclos(2);
      bus.H = 1'b1;
      ciclos(8);
      chk("glitch_nivel", 32'(bus.Nivel), 32'd3);

      // All zones dry, drip mode, each zone turns wet once served
      bus.T = 1'b1;
      for (int k = 0; k < 5; k++) push(k % NZ, 1'b1, 9, (k == 0) ? -1 : 5, 4'b0000);
      bus.Us = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         espera_ocup(1'b1, "rr_inicio");
         ciclos(1);
         if (k == 4) bus.Us = 4'b0000;
         else        bus.Us[k % NZ] = 1'b0;
         espera_ocup(1'b0, "rr_fim");
         if (k < 4) bus.Us[k % NZ] = 1'b1;
      end

      // Single zone in sprinkler mode, normal exit at the minimum time
      bus.T = 1'b0;
      push(1, 1'b0, 9, -1, 4'b0000);
      bus.Us = 4'b0010;
      espera_ocup(1'b1, "min_inicio");
      ciclos(1);
      bus.Us = 4'b0000;
      espera_ocup(1'b0, "min_fim");

      // Sprinkler abort when M drops, then the probe inconsistency
      push(0, 1'b0, 8, -1, 4'b0000);
      bus.Us = 4'b0001;
      espera_ocup(1'b1, "abort_inicio");
      ciclos(1);
      bus.M = 1'b0;
      espera_ocup(1'b0, "abort_fim");
      ciclos(3);
      chk("erro_hm",  32'(bus.Erro),  32'd1);
      chk("al_hm",    32'(bus.Al),    32'd1);
      chk("ve_hm",    32'(bus.Ve),    32'd0);
      chk("falha_hm", 32'(bus.Falha), 32'd0);
      chk("ocup_hm",  32'(bus.Ocupado), 32'd0);
      bus.Us = 4'b0000;
      ciclos(10);
      bus.M = 1'b1;
      ciclos(10);

      // Zone 2 never dries out: timeout, sticky flag, then skipped
      bus.T = 1'b1;
      push(2, 1'b1, 32, -1, 4'b0100);
      bus.Us = 4'b0100;
      espera_ocup(1'b1, "timeout_inicio");
      espera_ocup(1'b0, "timeout_fim");
      push(3, 1'b1, 9, -1, 4'b0100);
      bus.Us = 4'b1100;
      espera_ocup(1'b1, "pos_timeout_inicio");
      ciclos(1);
      bus.Us = 4'b0100;
      espera_ocup(1'b0, "pos_timeout_fim");
      ciclos(50);
      chk("salta_ocupado", 32'(bus.Ocupado), 32'd0);
      chk("salta_falha",   32'(bus.Falha),   32'b0100);

      // Reset in the middle of a sprinkler run
      bus.T = 1'b0;
      push(0, 1'b0, 4, -1, 4'b0000);
      bus.Us = 4'b0001;
      espera_ocup(1'b1, "reset_inicio");
      ciclos(3);
      Rst = 1'b0;
      bus.Us = 4'b0000;
      ciclos(1);
      verifica_reset("reset_rega");
      Rst = 1'b1;
      ciclos(5);

      chk("fila_vazia", 32'(fila.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
